bj_resolve: RTL and testbench
=============================

Name: bj_resolve

Overview:
- Execute-stage branch/jump resolution unit; the producer side of the BjBusIfs branch/jump bus.
- Evaluates the branch condition and target for each valid instruction.
- Drives a one-cycle registered redirect (FeBjEn/BjPc) into the fetch PC generator.
- Squashes the wrong-path instructions already in flight behind a taken branch through a shadow counter.

Parameters:
- XLEN, 32, datapath width.
- SHADOW_CYC, 2, number of issue slots after a redirect whose instructions are killed (fetch + decode depth). Legal range 1..7.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- iValid  in  1  instruction in EX this cycle
- iBjOp  in  4  BjOpType code
- iPc  in  XLEN  PC of the EX instruction
- iPcAdd4  in  XLEN  iPc+4, forwarded from fetch
- iRs1  in  XLEN  operand 1
- iRs2  in  XLEN  operand 2
- iImm  in  XLEN  sign-extended immediate
- iFlushExt  in  1  flush from a later stage (exception/trap)
- oBjBus  BjBusIfs.Ex  -  FeBjEn (1), BjPc (XLEN)
- oLinkEn  out  1  write link value to rd (JAL/JALR)
- oLinkData  out  XLEN  link value (iPcAdd4)
- oKill  out  1  current EX instruction is wrong-path
- oMisalign  out  1  taken target is not 4-byte aligned

Behaviour:
- Interface: single clock clk; reset rstn is synchronous, active-low. All state updates on posedge clk.
- Reset values: FeBjEn=0, BjPc=0, oLinkEn=0, oLinkData=0, oMisalign=0, shadow counter=0, state=IDLE. oKill=0 while in reset.
- Target computation:
  - JAL and all branches: iPc+iImm.
  - JALR: (iRs1+iImm) with bit0 cleared.
  - Additions are XLEN-wide modulo 2^XLEN; wrap-around is legal and not flagged.
- Taken condition:
  - JAL and JALR: always taken.
  - BEQ: rs1==rs2. BNE: rs1!=rs2.
  - BLT and BGE: signed compare.
  - BLTU and BGEU: unsigned compare.
  - NONE: never taken.
- Effective instruction: eff = iValid & ~oKill & ~iFlushExt.
- Taken, aligned target:
  - Condition: eff, taken, target[1:0]==0.
  - Next cycle: FeBjEn=1 and BjPc=target, held for exactly one cycle (1-cycle latency, registered).
- Misaligned taken target:
  - No redirect.
  - oMisalign=1 for one cycle (registered, same timing as FeBjEn).
  - Shadow is not started.
- Link write:
  - Condition: eff and op is JAL or JALR, taken or misaligned.
  - Next cycle: oLinkEn=1 and oLinkData=iPcAdd4.
- State machine:
  - IDLE -> SHADOW when a redirect is issued; counter loads SHADOW_CYC.
  - SHADOW: oKill = (counter!=0), combinational. The counter decrements every cycle, whether or not iValid is set.
  - SHADOW -> IDLE when the counter reaches 0.
  - Branches arriving in SHADOW are squashed: no redirect, no link, no misalign.
- iFlushExt:
  - Cancels the EX instruction that cycle.
  - Clears the counter to 0 and forces IDLE.
  - Suppresses any registered FeBjEn, oLinkEn or oMisalign that would be issued next cycle.
  - Wins over a simultaneous taken branch.
- Back-to-back:
  - A taken branch in the first slot after the shadow expires redirects normally.
  - There is no structural stall.
- Reset mid-shadow: counter and outputs return to reset values the next edge; no redirect is emitted.
- SHADOW_CYC == 1: exactly one instruction is killed.

Decomposition:
- ZionDataType package:
  - BjOpType enum (4 bits): NONE=0, JAL=1, JALR=2, BEQ=3, BNE=4, BLT=5, BGE=6, BLTU=7, BGEU=8. Others are reserved and decode as NONE.
  - CpuType (XLEN logic vector).
- BjBusIfs gains an Ex modport (output FeBjEn, BjPc).
- One natural sub-module: bj_cond_cmp. It is a combinational comparator producing taken from op/rs1/rs2, and is reusable by a later predictor check.

Test Plan:
- BEQ, iPc=0x200, imm=0x40, rs1=rs2=5 -> next cycle FeBjEn=1, BjPc=0x240. oKill=1 for the following 2 iValid cycles; the 3rd instruction is effective.
- BLT with rs1=0xFFFFFFFF, rs2=1 -> taken (signed). BLTU with the same operands -> not taken; FeBjEn stays 0 and oKill stays 0.
- JALR, rs1=0x1001, imm=0x3, iPcAdd4=0x304 -> BjPc=0x1004, oLinkEn=1, oLinkData=0x304. With imm=0x5 -> target 0x1006: oMisalign=1, FeBjEn=0, oLinkEn=1.
- Taken JAL followed immediately by taken BNE in the shadow -> only one FeBjEn pulse (first target); the BNE is killed.
- Taken BEQ with iFlushExt=1 in the same cycle -> FeBjEn=0 next cycle and no shadow. iFlushExt during SHADOW -> oKill drops the same cycle.
- rstn=0 for one edge mid-shadow (counter=1) -> next cycle all outputs 0 and state IDLE. JAL at iPc=0xFFFFFFF0, imm=0x20 -> BjPc=0x10 (wrap).

Source files
------------

// File: rtl/bj_resolve_pkg.sv
// Shared types for the execute-stage branch/jump resolution slice.
package bj_resolve_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] CpuType;

    // Branch/jump operation codes; unlisted encodings behave as NONE
    typedef enum logic [3:0] {
        NONE = 4'd0,
        JAL  = 4'd1,
        JALR = 4'd2,
        BEQ  = 4'd3,
        BNE  = 4'd4,
        BLT  = 4'd5,
        BGE  = 4'd6,
        BLTU = 4'd7,
        BGEU = 4'd8
    } BjOpType;

    // Resolution unit state: IDLE accepts redirects, SHADOW kills wrong-path slots
    typedef enum logic {
        IDLE   = 1'b0,
        SHADOW = 1'b1
    } BjStateType;

endpackage

// File: rtl/bj_bus_ifs.sv
// Branch/jump redirect bus between the execute stage and the fetch PC generator.
interface BjBusIfs #(
    parameter int XLEN = 32
);

    logic            FeBjEn;
    logic [XLEN-1:0] BjPc;

    modport Ex (output FeBjEn, output BjPc);
    modport Fe (input FeBjEn, input BjPc);

endinterface

// File: rtl/bj_cond_cmp.sv
// Combinational branch condition evaluator, shared with future predictor checks.
module bj_cond_cmp
    import bj_resolve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      bjOp_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o
);

    BjOpType opCode;

    assign opCode = BjOpType'(bjOp_i);

    // Decide taken from the operation and operands; reserved codes never take
    always_comb begin
        taken_o = 1'b0;
        case (opCode)
            JAL, JALR: taken_o = 1'b1;
            BEQ:       taken_o = (rs1_i == rs2_i);
            BNE:       taken_o = (rs1_i != rs2_i);
            BLT:       taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            BGE:       taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            BLTU:      taken_o = (rs1_i <  rs2_i);
            BGEU:      taken_o = (rs1_i >= rs2_i);
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bj_resolve.sv
// Execute-stage branch/jump resolution: registered redirect, link write and
// wrong-path squash through a shadow counter.
module bj_resolve
    import bj_resolve_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHADOW_CYC = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            iValid,
    input  logic [3:0]      iBjOp,
    input  logic [XLEN-1:0] iPc,
    input  logic [XLEN-1:0] iPcAdd4,
    input  logic [XLEN-1:0] iRs1,
    input  logic [XLEN-1:0] iRs2,
    input  logic [XLEN-1:0] iImm,
    input  logic            iFlushExt,
    BjBusIfs.Ex             oBjBus,
    output logic            oLinkEn,
    output logic [XLEN-1:0] oLinkData,
    output logic            oKill,
    output logic            oMisalign
);

    BjStateType      stateQ, stateD;
    logic [2:0]      cntQ, cntD;
    logic            feBjEnQ, feBjEnD;
    logic [XLEN-1:0] bjPcQ, bjPcD;
    logic            linkEnQ, linkEnD;
    logic [XLEN-1:0] linkDataQ, linkDataD;
    logic            misalignQ, misalignD;

    BjOpType         opCode;
    logic            taken;
    logic            eff;
    logic            isJump;
    logic [XLEN-1:0] jalrSum;
    logic [XLEN-1:0] target;
    logic            redirect;

    assign opCode  = BjOpType'(iBjOp);
    assign isJump  = (opCode == JAL) || (opCode == JALR);
    assign jalrSum = iRs1 + iImm;
    assign target  = (opCode == JALR) ? (jalrSum & {{(XLEN-1){1'b1}}, 1'b0})
                                      : (iPc + iImm);

    bj_cond_cmp #(
        .XLEN (XLEN)
    ) uCondCmp (
        .bjOp_i  (iBjOp),
        .rs1_i   (iRs1),
        .rs2_i   (iRs2),
        .taken_o (taken)
    );

    // Kill is live only while shadow slots remain; a flush or reset drops it at once
    always_comb begin
        oKill = rstn && !iFlushExt && (stateQ == SHADOW) && (cntQ != 3'd0);
    end

    assign eff      = iValid && !oKill && !iFlushExt;
    assign redirect = eff && taken && (target[1:0] == 2'b00);

    // Next-state for the shadow FSM and the one-cycle registered outputs
    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        feBjEnD   = redirect;
        bjPcD     = redirect ? target : '0;
        misalignD = eff && taken && (target[1:0] != 2'b00);
        linkEnD   = eff && isJump;
        linkDataD = (eff && isJump) ? iPcAdd4 : '0;
        if (iFlushExt) begin
            stateD = IDLE;
            cntD   = 3'd0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (redirect) begin
                        stateD = SHADOW;
                        cntD   = 3'(SHADOW_CYC);
                    end
                end
                SHADOW: begin
                    if (cntQ != 3'd0) begin
                        cntD = cntQ - 3'd1;
                    end
                    if (cntQ <= 3'd1) begin
                        stateD = IDLE;
                    end
                end
                default: begin
                    stateD = IDLE;
                    cntD   = 3'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stateQ    <= IDLE;
            cntQ      <= 3'd0;
            feBjEnQ   <= 1'b0;
            bjPcQ     <= '0;
            linkEnQ   <= 1'b0;
            linkDataQ <= '0;
            misalignQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            feBjEnQ   <= feBjEnD;
            bjPcQ     <= bjPcD;
            linkEnQ   <= linkEnD;
            linkDataQ <= linkDataD;
            misalignQ <= misalignD;
        end
    end

    assign oBjBus.FeBjEn = feBjEnQ;
    assign oBjBus.BjPc   = bjPcQ;
    assign oLinkEn       = linkEnQ;
    assign oLinkData     = linkDataQ;
    assign oMisalign     = misalignQ;

endmodule

// File: tb/tb_bj_resolve.sv
// Self-checking bench for bj_resolve: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_bj_resolve;

    localparam int XLEN       = 32;
    localparam int SHADOW_CYC = 2;

    logic            clk;
    logic            rstn;
    logic            iValid;
    logic [3:0]      iBjOp;
    logic [XLEN-1:0] iPc;
    logic [XLEN-1:0] iPcAdd4;
    logic [XLEN-1:0] iRs1;
    logic [XLEN-1:0] iRs2;
    logic [XLEN-1:0] iImm;
    logic            iFlushExt;
    logic            oLinkEn;
    logic [XLEN-1:0] oLinkData;
    logic            oKill;
    logic            oMisalign;

    BjBusIfs #(.XLEN(XLEN)) bjBus ();

    bj_resolve #(
        .XLEN       (XLEN),
        .SHADOW_CYC (SHADOW_CYC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .iValid    (iValid),
        .iBjOp     (iBjOp),
        .iPc       (iPc),
        .iPcAdd4   (iPcAdd4),
        .iRs1      (iRs1),
        .iRs2      (iRs2),
        .iImm      (iImm),
        .iFlushExt (iFlushExt),
        .oBjBus    (bjBus),
        .oLinkEn   (oLinkEn),
        .oLinkData (oLinkData),
        .oKill     (oKill),
        .oMisalign (oMisalign)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: remaining wrong-path slots and expected registered outputs
    int              mShadow = 0;
    logic            expKill;
    logic            killSeen;
    logic            expFe;
    logic [XLEN-1:0] expPc;
    logic            expLinkEn;
    logic [XLEN-1:0] expLinkData;
    logic            expMis;

    function automatic logic refTaken(input logic [3:0] op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd1, 4'd2: return 1'b1;
            4'd3:       return a == b;
            4'd4:       return a != b;
            4'd5:       return sa < sb;
            4'd6:       return sa >= sb;
            4'd7:       return a < b;
            4'd8:       return a >= b;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] refTarget(input logic [3:0] op, input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] imm);
        logic [XLEN-1:0] sum;
        if (op == 4'd2) begin
            sum = rs1 + imm;
            sum[0] = 1'b0;
        end else begin
            sum = pc + imm;
        end
        return sum;
    endfunction

    // Advance the model from the current inputs, capture oKill, then pass one edge
    task automatic step();
        logic            t;
        logic            eff;
        logic [XLEN-1:0] tgt;
        logic            redir;
        #1;
        killSeen = oKill;
        expKill  = rstn && !iFlushExt && (mShadow > 0);
        if (!rstn || iFlushExt) begin
            mShadow     = 0;
            expFe       = 1'b0;
            expPc       = '0;
            expLinkEn   = 1'b0;
            expLinkData = '0;
            expMis      = 1'b0;
        end else begin
            eff   = iValid && !expKill;
            t     = refTaken(iBjOp, iRs1, iRs2);
            tgt   = refTarget(iBjOp, iPc, iRs1, iImm);
            redir = eff && t && (tgt % 4 == 0);
            expFe       = redir;
            expPc       = redir ? tgt : '0;
            expMis      = eff && t && (tgt % 4 != 0);
            expLinkEn   = eff && (iBjOp == 4'd1 || iBjOp == 4'd2);
            expLinkData = expLinkEn ? iPcAdd4 : '0;
            if (mShadow > 0) mShadow = mShadow - 1;
            if (redir) mShadow = SHADOW_CYC;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [XLEN-1:0] pc,
                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] imm);
        iValid    = v;
        iBjOp     = op;
        iPc       = pc;
        iPcAdd4   = pc + 32'd4;
        iRs1      = rs1;
        iRs2      = rs2;
        iImm      = imm;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 4'd0, '0, '0, '0, '0);
            step();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        iFlushExt = 1'b0;
        drive(1'b1, 4'd1, 32'h100, '0, '0, 32'h40);
        step();
        step();
        checks++;
        if (bjBus.FeBjEn !== 1'b0 || bjBus.BjPc !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_bus got=%0b/%h want=0/0", bjBus.FeBjEn, bjBus.BjPc);
        end
        checks++;
        if (oLinkEn !== 1'b0 || oLinkData !== 32'h0 || oMisalign !== 1'b0 || killSeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outs got=%0b/%h/%0b/%0b want=0/0/0/0",
                     oLinkEn, oLinkData, oMisalign, killSeen);
        end
        rstn = 1'b1;
        idle(1);
    endtask

    task automatic test_beq_shadow();
        drive(1'b1, 4'd3, 32'h200, 32'd5, 32'd5, 32'h40);
        step();
        checks++;
        if (bjBus.FeBjEn !== 1'b1 || bjBus.BjPc !== 32'h240) begin
            failures++;
            $display("[TB] FAIL beq_redirect got=%0b/%h want=1/00000240", bjBus.FeBjEn, bjBus.BjPc);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd0, 32'h204 + 32'(4 * k), '0, '0, '0);
            step();
            checks++;
            if (killSeen !== (k < 2)) begin
                failures++;
                $display("[TB] FAIL beq_kill_slot%0d got=%0b want=%0b", k, killSeen, k < 2);
            end
        end
        checks++;
        if (bjBus.FeBjEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL beq_single_pulse got=%0b want=0", bjBus.FeBjEn);
        end
    endtask

    task automatic test_signed_unsigned();
        drive(1'b1, 4'd5, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h8);
        step();
        checks++;
        if (bjBus.FeBjEn !== 1'b1 || bjBus.BjPc !== 32'h108) begin
            failures++;
            $display("[TB] FAIL blt_taken got=%0b/%h want=1/00000108", bjBus.FeBjEn, bjBus.BjPc);
        end
        idle(2);
        drive(1'b1, 4'd7, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h8);
        step();
        checks++;
        if (bjBus.FeBjEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bltu_not_taken got=%0b want=0", bjBus.FeBjEn);
        end
        drive(1'b1, 4'd0, 32'h104, '0, '0, '0);
        step();
        checks++;
        if (killSeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bltu_no_kill got=%0b want=0", killSeen);
        end
    endtask

    task automatic test_jalr();
        drive(1'b1, 4'd2, 32'h300, 32'h1001, '0, 32'h3);
        step();
        checks++;
        if (bjBus.FeBjEn !== 1'b1 || bjBus.BjPc !== 32'h1004 || oLinkEn !== 1'b1 || oLinkData !== 32'h304) begin
            failures++;
            $display("[TB] FAIL jalr_aligned got=%0b/%h/%0b/%h want=1/00001004/1/00000304",
                     bjBus.FeBjEn, bjBus.BjPc, oLinkEn, oLinkData);
        end
        idle(2);
        drive(1'b1, 4'd2, 32'h300, 32'h1001, '0, 32'h5);
        step();
        checks++;
        if (oMisalign !== 1'b1 || bjBus.FeBjEn !== 1'b0 || oLinkEn !== 1'b1 || oLinkData !== 32'h304) begin
            failures++;
            $display("[TB] FAIL jalr_misalign got=%0b/%0b/%0b/%h want=1/0/1/00000304",
                     oMisalign, bjBus.FeBjEn, oLinkEn, oLinkData);
        end
        drive(1'b1, 4'd0, 32'h304, '0, '0, '0);
        step();
        checks++;
        if (killSeen !== 1'b0 || oMisalign !== 1'b0) begin
            failures++;
            $display("[TB] FAIL misalign_no_shadow got=%0b/%0b want=0/0", killSeen, oMisalign);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        drive(1'b1, 4'd1, 32'h400, '0, '0, 32'h100);
        step();
        if (bjBus.FeBjEn === 1'b1) pulses++;
        checks++;
        if (bjBus.BjPc !== 32'h500) begin
            failures++;
            $display("[TB] FAIL b2b_first_target got=%h want=00000500", bjBus.BjPc);
        end
        drive(1'b1, 4'd4, 32'h404, 32'd1, 32'd2, 32'h80);
        step();
        if (bjBus.FeBjEn === 1'b1) pulses++;
        checks++;
        if (killSeen !== 1'b1 || oLinkEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_bne_killed got=%0b/%0b want=1/0", killSeen, oLinkEn);
        end
        drive(1'b1, 4'd0, 32'h408, '0, '0, '0);
        step();
        if (bjBus.FeBjEn === 1'b1) pulses++;
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("[TB] FAIL b2b_pulse_count got=%0d want=1", pulses);
        end
        drive(1'b1, 4'd3, 32'h500, 32'd7, 32'd7, 32'h20);
        step();
        checks++;
        if (killSeen !== 1'b0 || bjBus.FeBjEn !== 1'b1 || bjBus.BjPc !== 32'h520) begin
            failures++;
            $display("[TB] FAIL b2b_after_shadow got=%0b/%0b/%h want=0/1/00000520",
                     killSeen, bjBus.FeBjEn, bjBus.BjPc);
        end
        idle(2);
    endtask

    task automatic test_flush();
        drive(1'b1, 4'd3, 32'h600, 32'd9, 32'd9, 32'h40);
        iFlushExt = 1'b1;
        step();
        iFlushExt = 1'b0;
        checks++;
        if (bjBus.FeBjEn !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_same_cycle got=%0b want=0", bjBus.FeBjEn);
        end
        drive(1'b1, 4'd3, 32'h604, 32'd9, 32'd9, 32'h40);
        step();
        checks++;
        if (killSeen !== 1'b0 || bjBus.FeBjEn !== 1'b1 || bjBus.BjPc !== 32'h644) begin
            failures++;
            $display("[TB] FAIL flush_no_shadow got=%0b/%0b/%h want=0/1/00000644",
                     killSeen, bjBus.FeBjEn, bjBus.BjPc);
        end
        drive(1'b1, 4'd0, 32'h608, '0, '0, '0);
        #1;
        checks++;
        if (oKill !== 1'b1) begin
            failures++;
            $display("[TB] FAIL shadow_before_flush got=%0b want=1", oKill);
        end
        iFlushExt = 1'b1;
        step();
        iFlushExt = 1'b0;
        checks++;
        if (killSeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_drops_kill got=%0b want=0", killSeen);
        end
        drive(1'b1, 4'd0, 32'h60C, '0, '0, '0);
        step();
        checks++;
        if (killSeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_clears_counter got=%0b want=0", killSeen);
        end
    endtask

    task automatic test_reset_mid_shadow();
        drive(1'b1, 4'd1, 32'h700, '0, '0, 32'h40);
        step();
        drive(1'b1, 4'd0, 32'h704, '0, '0, '0);
        step();
        drive(1'b1, 4'd1, 32'h708, '0, '0, 32'h80);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checks++;
        if (killSeen !== 1'b0 || bjBus.FeBjEn !== 1'b0 || bjBus.BjPc !== 32'h0 || oLinkEn !== 1'b0 ||
            oLinkData !== 32'h0 || oMisalign !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_shadow got=%0b/%0b/%h/%0b/%h/%0b want=all zero",
                     killSeen, bjBus.FeBjEn, bjBus.BjPc, oLinkEn, oLinkData, oMisalign);
        end
        drive(1'b1, 4'd0, 32'h70C, '0, '0, '0);
        step();
        checks++;
        if (killSeen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_back_to_idle got=%0b want=0", killSeen);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 4'd1, 32'hFFFF_FFF0, '0, '0, 32'h20);
        step();
        checks++;
        if (bjBus.FeBjEn !== 1'b1 || bjBus.BjPc !== 32'h10 || oLinkData !== 32'hFFFF_FFF4) begin
            failures++;
            $display("[TB] FAIL jal_wrap got=%0b/%h/%h want=1/00000010/fffffff4",
                     bjBus.FeBjEn, bjBus.BjPc, oLinkData);
        end
        idle(2);
    endtask

    task automatic test_random();
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] immR;
        for (int n = 0; n < 400; n++) begin
            r1   = $urandom;
            immR = $urandom;
            if ($urandom_range(0, 5) != 0) immR[1:0] = 2'b00;
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 10)),
                  {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, r1,
                  ($urandom_range(0, 2) == 0) ? r1 : 32'($urandom), immR);
            iFlushExt = ($urandom_range(0, 11) == 0);
            rstn      = ($urandom_range(0, 59) != 0);
            step();
            checks++;
            if (killSeen !== expKill) begin
                failures++;
                $display("[TB] FAIL rnd_kill n=%0d got=%0b want=%0b", n, killSeen, expKill);
            end
            checks++;
            if (bjBus.FeBjEn !== expFe || bjBus.BjPc !== expPc) begin
                failures++;
                $display("[TB] FAIL rnd_redirect n=%0d got=%0b/%h want=%0b/%h",
                         n, bjBus.FeBjEn, bjBus.BjPc, expFe, expPc);
            end
            checks++;
            if (oLinkEn !== expLinkEn || oLinkData !== expLinkData) begin
                failures++;
                $display("[TB] FAIL rnd_link n=%0d got=%0b/%h want=%0b/%h",
                         n, oLinkEn, oLinkData, expLinkEn, expLinkData);
            end
            checks++;
            if (oMisalign !== expMis) begin
                failures++;
                $display("[TB] FAIL rnd_misalign n=%0d got=%0b want=%0b", n, oMisalign, expMis);
            end
        end
        iFlushExt = 1'b0;
        rstn      = 1'b1;
    endtask

    // Scenario sequence, ending in the single summary line
    initial begin
        rstn      = 1'b0;
        iFlushExt = 1'b0;
        drive(1'b0, 4'd0, '0, '0, '0, '0);
        @(negedge clk);
        test_reset();
        test_beq_shadow();
        test_signed_unsigned();
        test_jalr();
        test_back_to_back();
        test_flush();
        test_reset_mid_shadow();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
